// File: rtl/comproc_pkg.sv
// comproc_pkg: types and constants shared by the comproc stack CPU decoder.
//   src_a_t  - ALU A-source select codes
//   ALU_*    - ALU function codes used by the decoder
//   OP_*     - opcode group values of insn[15:12] (insn[15]=0 is push uimm15)
//   ctrl_t   - packed control bundle driven to the datapath
package comproc_pkg;

    typedef enum logic [1:0] {
        SRC_STK0 = 2'd0,
        SRC_FP   = 2'd1,
        SRC_IP   = 2'd2,
        SRC_CSTK = 2'd3
    } src_a_t;

    localparam logic [5:0] ALU_PASS_A = 6'h00;
    localparam logic [5:0] ALU_PASS_B = 6'h0F;
    localparam logic [5:0] ALU_AND    = 6'h10;
    localparam logic [5:0] ALU_ADD    = 6'h20;

    // insn[14:12] when insn[15]=1
    localparam logic [2:0] OP_JMP   = 3'b000;
    localparam logic [2:0] OP_ADDFP = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_ALU   = 3'b111;

    localparam logic [15:0] MASK_UIMM15 = 16'h7FFF;
    localparam logic [15:0] MASK_REL12  = 16'h0FFE;
    localparam logic [15:0] MASK_MEM10  = 16'h03FE;

    typedef struct packed {
        logic        imm;
        logic [15:0] imm_mask;
        src_a_t      src_a;
        logic [5:0]  alu_sel;
        logic        wr_stk1;
        logic        load;
        logic        pop;
        logic        push;
        logic        load_fp;
        logic        load_ip;
        logic        byt;
        logic        wr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/insn_decode_comb.sv
// insn_decode_comb: purely combinational map from a 16-bit comproc
// instruction word to the datapath control bundle.
//   insn  in  16       instruction word
//   ctrl  out ctrl_t   decoded controls (NOP bundle for reserved encodings)
module insn_decode_comb
    import comproc_pkg::*;
(
    input  logic [15:0] insn,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        if (!insn[15]) begin
            ctrl.imm      = 1'b1;
            ctrl.imm_mask = MASK_UIMM15;
            ctrl.alu_sel  = ALU_PASS_B;
            ctrl.push     = 1'b1;
        end else begin
            case (insn[14:12])
                OP_JMP: begin
                    ctrl.imm      = 1'b1;
                    ctrl.imm_mask = MASK_REL12;
                    ctrl.src_a    = SRC_IP;
                    ctrl.alu_sel  = ALU_ADD;
                    ctrl.load_ip  = 1'b1;
                end
                OP_ADDFP: begin
                    ctrl.imm      = 1'b1;
                    ctrl.imm_mask = MASK_REL12;
                    ctrl.src_a    = SRC_FP;
                    ctrl.alu_sel  = ALU_ADD;
                    ctrl.load_fp  = 1'b1;
                end
                OP_LOAD, OP_STORE: begin
                    ctrl.imm      = 1'b1;
                    ctrl.imm_mask = MASK_MEM10;
                    ctrl.src_a    = src_a_t'(insn[11:10]);
                    ctrl.alu_sel  = ALU_ADD;
                    ctrl.byt      = insn[0];
                    if (insn[12]) begin
                        ctrl.wr  = 1'b1;
                        ctrl.pop = 1'b1;
                    end else begin
                        ctrl.load = 1'b1;
                        // With base stk0 the loaded data overwrites the address on top.
                        ctrl.push = (insn[11:10] != SRC_STK0);
                    end
                end
                OP_ALU: begin
                    if (insn[11:7] == 5'd0) begin
                        ctrl.src_a   = SRC_STK0;
                        ctrl.alu_sel = insn[5:0];
                        ctrl.pop     = insn[6];
                    end
                end
                default: ctrl = CTRL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/insn_decoder.sv
// insn_decoder: registered instruction decoder for the comproc stack CPU.
// Decodes insn every cycle with one cycle of latency; reset forces the NOP
// bundle asynchronously.
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   async active-low reset
//   insn      in  16   instruction word
//   imm       out  1   ALU B operand is insn & imm_mask
//   imm_mask  out 16   immediate field mask
//   src_a     out  2   ALU A source (stk0, fp, ip, cstk)
//   alu_sel   out  6   ALU function code
//   wr_stk1   out  1   write result into stack entry 1
//   load      out  1   memory read
//   pop       out  1   pop data stack
//   push      out  1   push data stack
//   load_fp   out  1   FP <= ALU result
//   load_ip   out  1   IP <= ALU result
//   byt       out  1   byte-wide memory access
//   wr        out  1   memory write
module insn_decoder
    import comproc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] insn,
    output logic        imm,
    output logic [15:0] imm_mask,
    output logic [1:0]  src_a,
    output logic [5:0]  alu_sel,
    output logic        wr_stk1,
    output logic        load,
    output logic        pop,
    output logic        push,
    output logic        load_fp,
    output logic        load_ip,
    output logic        byt,
    output logic        wr
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    insn_decode_comb u_decode (
        .insn (insn),
        .ctrl (ctrl_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign imm      = ctrl_q.imm;
    assign imm_mask = ctrl_q.imm_mask;
    assign src_a    = ctrl_q.src_a;
    assign alu_sel  = ctrl_q.alu_sel;
    assign wr_stk1  = ctrl_q.wr_stk1;
    assign load     = ctrl_q.load;
    assign pop      = ctrl_q.pop;
    assign push     = ctrl_q.push;
    assign load_fp  = ctrl_q.load_fp;
    assign load_ip  = ctrl_q.load_ip;
    assign byt      = ctrl_q.byt;
    assign wr       = ctrl_q.wr;

endmodule

// File: tb/tb_insn_decoder.sv
// tb_insn_decoder: directed and randomized checks of insn_decoder against a
// behavioural decode model written directly from the instruction table.
module tb_insn_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] insn = 16'h0000;
    logic        imm;
    logic [15:0] imm_mask;
    logic [1:0]  src_a;
    logic [5:0]  alu_sel;
    logic        wr_stk1, load, pop, push, load_fp, load_ip, byt, wr;

    int n_checks = 0;
    int n_errors = 0;

    insn_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .insn     (insn),
        .imm      (imm),
        .imm_mask (imm_mask),
        .src_a    (src_a),
        .alu_sel  (alu_sel),
        .wr_stk1  (wr_stk1),
        .load     (load),
        .pop      (pop),
        .push     (push),
        .load_fp  (load_fp),
        .load_ip  (load_ip),
        .byt      (byt),
        .wr       (wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observed();
        return {31'd0, imm, imm_mask, src_a, alu_sel, wr_stk1, load, pop, push,
                load_fp, load_ip, byt, wr};
    endfunction

    // Reference: decode straight from the opcode table using integer fields.
    function automatic logic [63:0] model(input logic [15:0] w);
        int op, base, sub;
        logic        m_imm, m_wr_stk1, m_load, m_pop, m_push, m_lfp, m_lip, m_byt, m_wr;
        logic [15:0] m_mask;
        logic [1:0]  m_src;
        logic [5:0]  m_alu;
        op   = int'(w) / 4096;
        base = (int'(w) / 1024) % 4;
        sub  = (int'(w) / 128) % 32;
        {m_imm, m_wr_stk1, m_load, m_pop, m_push, m_lfp, m_lip, m_byt, m_wr} = '0;
        m_mask = 16'h0000; m_src = 2'd0; m_alu = 6'd0;
        if (op < 8) begin
            m_imm = 1; m_mask = 16'h7FFF; m_alu = 6'h0F; m_push = 1;
        end else if (op == 8 || op == 9) begin
            m_imm = 1; m_mask = 16'h0FFE; m_alu = 6'h20;
            m_src = (op == 8) ? 2'd2 : 2'd1;
            m_lip = (op == 8);
            m_lfp = (op == 9);
        end else if (op == 10 || op == 11) begin
            m_imm = 1; m_mask = 16'h03FE; m_alu = 6'h20;
            m_src = 2'(base);
            m_byt = (int'(w) % 2 == 1);
            if (op == 10) begin
                m_load = 1; m_push = (base != 0);
            end else begin
                m_wr = 1; m_pop = 1;
            end
        end else if (op == 15 && sub == 0) begin
            m_alu = 6'(int'(w) % 64);
            m_pop = ((int'(w) / 64) % 2 == 1);
        end
        return {31'd0, m_imm, m_mask, m_src, m_alu, m_wr_stk1, m_load, m_pop, m_push,
                m_lfp, m_lip, m_byt, m_wr};
    endfunction

    task automatic step(input logic [15:0] w, input string tag);
        @(negedge clk);
        insn = w;
        @(posedge clk);
        #1;
        check(tag, observed(), model(w));
    endtask

    initial begin
        logic [15:0] r;

        // Reset held with clocks running and a decodable insn present.
        insn = 16'h0BEF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", observed(), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("push_after_rst", observed(), model(16'h0BEF));
        check("push_mask", {48'd0, imm_mask}, 64'h7FFF);
        check("push_alu", {58'd0, alu_sel}, 64'h0F);

        step(16'h8020, "jmp");
        check("jmp_src", {62'd0, src_a}, 64'd2);
        check("jmp_ldip", {63'd0, load_ip}, 64'd1);

        step(16'hB430, "store_w");
        check("store_mask", {48'd0, imm_mask}, 64'h03FE);
        check("store_wrpop", {62'd0, wr, pop}, 64'd3);
        step(16'hB431, "store_b");
        check("store_byt", {63'd0, byt}, 64'd1);

        step(16'hF050, "alu_bin");
        check("alu_bin_pop", {58'd0, alu_sel}, 64'h10);
        step(16'hF010, "alu_un");
        check("alu_un_pop", {63'd0, pop}, 64'd0);

        step(16'hA402, "load_fp");
        check("load_fp_push", {63'd0, push}, 64'd1);
        step(16'hA002, "load_stk0");
        check("load_stk0_push", {63'd0, push}, 64'd0);

        step(16'h9FFF, "addfp");
        step(16'h7FFF, "push_max");
        step(16'hC123, "rsvd_c");
        check("rsvd_c_nop", observed(), 64'd0);
        step(16'hF850, "rsvd_f");
        check("rsvd_f_nop", observed(), 64'd0);
        step(16'hD000, "rsvd_d");
        step(16'hE0FF, "rsvd_e");
        step(16'hF07F, "alu_max");

        // Reset asserted between edges clears outputs without a clock edge.
        step(16'h0BEF, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", observed(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h8020, "post_async");

        for (int i = 0; i < 400; i++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
            if ($urandom_range(0, 2) == 0) r[15:12] = 4'hF;
            step(r, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
